// File: rtl/nes_controller_responder.sv
// NES controller responder: device-side end of the serial controller link.
// Emulates a 4021 shift register: buttons are captured while latch is high and
// shifted out active-low, one bit per synchronized pulse rising edge.
// Optional turbo on A/B is built only when NES_RESPONDER_TURBO_EN is defined.
module nes_controller_responder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic        TAIL_LEVEL     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       CONTROLLER_LATCH,
  input  logic       CONTROLLER_PULSE,
  output logic       CONTROLLER_DATA,
  input  logic [7:0] buttons,
  output logic       readDone,
  output logic [3:0] bitIndex,
  output logic [7:0] latchCount
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShifting,
    StDone
  } state_e;

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] pulse_sync_q;
  logic                   latch_prev_q;
  logic                   pulse_prev_q;

  logic latch_s, pulse_s;
  logic latch_rise, latch_fall, pulse_rise, pulse_edge;

  state_e        state_q, state_d;
  logic [7:0]    snapshot_q, snapshot_d;
  logic          data_q, data_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          done_q, done_d;
  logic [7:0]    count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic [7:0]    load_word;

`ifdef NES_RESPONDER_TURBO_EN
  logic turbo_q, turbo_d;
`endif

  // Input synchronizers followed by a one-flop edge detector
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      latch_sync_q <= '0;
      pulse_sync_q <= '0;
      latch_prev_q <= 1'b0;
      pulse_prev_q <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], CONTROLLER_LATCH};
      pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], CONTROLLER_PULSE};
      latch_prev_q <= latch_s;
      pulse_prev_q <= pulse_s;
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev_q;
  assign latch_fall = ~latch_s & latch_prev_q;
  assign pulse_rise = pulse_s & ~pulse_prev_q;
  assign pulse_edge = pulse_s ^ pulse_prev_q;

  // Fires on the cycle the silent-cycle count would reach the limit
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (32'(tmo_q) == TIMEOUT_CYCLES - 32'd1);

  // Word captured during LOAD; turbo masks A/B on alternate reads
  always_comb begin
    load_word = buttons;
`ifdef NES_RESPONDER_TURBO_EN
    load_word[1:0] = buttons[1:0] & {2{turbo_q}};
`endif
  end

  // Responder state and output registers
  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      state_q    <= StIdle;
      snapshot_q <= 8'h00;
      data_q     <= 1'b1;
      bit_idx_q  <= 4'd0;
      done_q     <= 1'b0;
      count_q    <= 8'd0;
      tmo_q      <= '0;
`ifdef NES_RESPONDER_TURBO_EN
      turbo_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      snapshot_q <= snapshot_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      done_q     <= done_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
`ifdef NES_RESPONDER_TURBO_EN
      turbo_q    <= turbo_d;
`endif
    end
  end

  // Next-state logic: load, shift, abort and timeout decisions
  always_comb begin
    state_d    = state_q;
    snapshot_d = snapshot_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    done_d     = 1'b0;
    count_d    = count_q;
    tmo_d      = tmo_q;
`ifdef NES_RESPONDER_TURBO_EN
    turbo_d    = turbo_q;
`endif

    unique case (state_q)
      StIdle: begin
        data_d = 1'b1;
        tmo_d  = '0;
        if (latch_s) state_d = StLoad;
      end

      StLoad: begin
        // Keep tracking the buttons up to and including the latch-fall cycle
        snapshot_d = load_word;
        data_d     = ~load_word[0];
        bit_idx_d  = 4'd0;
        tmo_d      = '0;
        if (latch_fall) begin
          count_d = count_q + 8'd1;
`ifdef NES_RESPONDER_TURBO_EN
          turbo_d = ~turbo_q;
`endif
          state_d = StShifting;
        end
      end

      StShifting: begin
        if (latch_rise) begin
          // Latch wins over a coincident pulse; partial read is dropped
          state_d = StLoad;
          tmo_d   = '0;
        end else begin
          if (pulse_rise) begin
            snapshot_d = {1'b0, snapshot_q[7:1]};
            bit_idx_d  = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd7) begin
              data_d  = TAIL_LEVEL;
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              data_d = ~snapshot_q[1];
            end
          end
          if (pulse_edge) begin
            tmo_d = '0;
          end else if (tmo_hit) begin
            state_d = StIdle;
            data_d  = 1'b1;
            tmo_d   = '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end

      StDone: begin
        data_d = TAIL_LEVEL;
        if (latch_rise) state_d = StLoad;
      end

      default: state_d = StIdle;
    endcase
  end

  assign CONTROLLER_DATA = data_q;
  assign readDone        = done_q;
  assign bitIndex        = bit_idx_q;
  assign latchCount      = count_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Self-checking bench for nes_controller_responder: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against a
// read-session model. Works with or without NES_RESPONDER_TURBO_EN.
module tb_nes_controller_responder;

  localparam int unsigned S   = 2;
  localparam logic        TL  = 1'b0;
  localparam int unsigned TMO = 100;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       latch = 1'b0;
  logic       pulse = 1'b0;
  logic [7:0] btn   = 8'h00;
  logic       data;
  logic       done;
  logic [3:0] bidx;
  logic [7:0] lcnt;

  nes_controller_responder #(
    .SYNC_STAGES   (S),
    .TAIL_LEVEL    (TL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pixelClock      (clk),
    .resetN          (rst_n),
    .CONTROLLER_LATCH(latch),
    .CONTROLLER_PULSE(pulse),
    .CONTROLLER_DATA (data),
    .buttons         (btn),
    .readDone        (done),
    .bitIndex        (bidx),
    .latchCount      (lcnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int n_done   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model: one read session ----------------
  // Inputs reach the decision logic S edges after capture; the model keeps a
  // short history of sampled inputs and reasons about latch/pulse events.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_SHIFT = 2, PH_DONE = 3;

  bit         m_valid = 1'b0;
  int         m_phase;
  logic [7:0] m_word;
  int         m_n;
  logic       m_data;
  logic       m_done;
  logic [7:0] m_cnt;
  int         m_gap;
  logic       m_turbo;
  logic       hl[0:S+1];
  logic       hp[0:S+1];

  always @(posedge clk) begin
    logic cur_l, prev_l, cur_p, prev_p;
    logic [7:0] w;
    if (!rst_n) begin
      for (int k = 0; k <= S + 1; k++) begin
        hl[k] = 1'b0;
        hp[k] = 1'b0;
      end
      m_phase = PH_IDLE;
      m_word  = 8'h00;
      m_n     = 0;
      m_data  = 1'b1;
      m_done  = 1'b0;
      m_cnt   = 8'd0;
      m_gap   = 0;
      m_turbo = 1'b1;
      m_valid = 1'b1;
    end else begin
      for (int k = S + 1; k > 0; k--) begin
        hl[k] = hl[k-1];
        hp[k] = hp[k-1];
      end
      hl[0]  = latch;
      hp[0]  = pulse;
      cur_l  = hl[S];
      prev_l = hl[S+1];
      cur_p  = hp[S];
      prev_p = hp[S+1];
      m_done = 1'b0;
      case (m_phase)
        PH_IDLE: begin
          m_data = 1'b1;
          if (cur_l) m_phase = PH_LOAD;
        end
        PH_LOAD: begin
          w = btn;
`ifdef NES_RESPONDER_TURBO_EN
          if (!m_turbo) w[1:0] = 2'b00;
`endif
          m_word = w;
          m_data = ~w[0];
          m_n    = 0;
          if (!cur_l && prev_l) begin
            m_cnt   = m_cnt + 8'd1;
            m_turbo = ~m_turbo;
            m_phase = PH_SHIFT;
            m_gap   = 0;
          end
        end
        PH_SHIFT: begin
          if (cur_l && !prev_l) begin
            m_phase = PH_LOAD;
          end else begin
            if (cur_p && !prev_p) begin
              m_n = m_n + 1;
              if (m_n == 8) begin
                m_data  = TL;
                m_done  = 1'b1;
                m_phase = PH_DONE;
              end else begin
                m_data = ~m_word[m_n];
              end
            end
            if (cur_p != prev_p) begin
              m_gap = 0;
            end else if (TMO != 0) begin
              m_gap = m_gap + 1;
              if (m_gap == TMO) begin
                m_phase = PH_IDLE;
                m_data  = 1'b1;
              end
            end
          end
        end
        default: begin
          m_data = TL;
          if (cur_l && !prev_l) m_phase = PH_LOAD;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("data", 32'(data), 32'(m_data));
      chk("readDone", 32'(done), 32'(m_done));
      chk("bitIndex", 32'(bidx), 32'(m_n));
      chk("latchCount", 32'(lcnt), 32'(m_cnt));
    end
  end

  // Count readDone strobes seen
  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    latch = 1'b0;
    pulse = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic do_latch();
    latch = 1'b1;
    tick(4);
    latch = 1'b0;
    tick(5);
  endtask

  task automatic do_pulse();
    pulse = 1'b1;
    tick(4);
    pulse = 1'b0;
    tick(4);
  endtask

  // DATA sampled before each of 8 pulses
  task automatic read_bits(output logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      seq[i] = data;
      do_pulse();
    end
  endtask

  initial begin
    logic [7:0] seq;
    logic [1:0] exp_ab;
    int done_before;

    do_reset();
    tick(15);
    chk("reset_data", 32'(data), 32'd1);
    chk("reset_bitIndex", 32'(bidx), 32'd0);
    chk("reset_latchCount", 32'(lcnt), 32'd0);
    chk("reset_no_readDone", 32'(n_done), 32'd0);

    // A + Select
    btn = 8'h05;
    do_latch();
    read_bits(seq);
    chk("seq_05", 32'(seq), 32'hFA);
    chk("tail_after_read", 32'(data), 32'(TL));
    chk("readDone_once", 32'(n_done), 32'd1);
    chk("latchCount_1", 32'(lcnt), 32'd1);

    // Buttons change after latch falls
    btn = 8'h05;
    do_latch();
    btn = 8'hFF;
    read_bits(seq);
    chk("seq_frozen", 32'(seq), 32'hFA);
    do_pulse();
    do_pulse();
    chk("extra_pulse_data", 32'(data), 32'(TL));
    chk("extra_pulse_bitIndex", 32'(bidx), 32'd8);
    chk("readDone_twice", 32'(n_done), 32'd2);

    // Re-latch mid read
    btn = 8'h80;
    do_latch();
    do_pulse();
    do_pulse();
    do_pulse();
    do_latch();
    chk("abort_no_readDone", 32'(n_done), 32'd2);
    chk("relatch_bitIndex", 32'(bidx), 32'd0);
    read_bits(seq);
    chk("seq_80", 32'(seq), 32'h7F);
    chk("readDone_after_restart", 32'(n_done), 32'd3);

    // Timeout after 2 pulses
    btn = 8'h04;
    do_latch();
    do_pulse();
    do_pulse();
    tick(50);
    chk("pre_timeout_data", 32'(data), 32'd0);
    tick(70);
    chk("post_timeout_data", 32'(data), 32'd1);
    chk("timeout_no_readDone", 32'(n_done), 32'd3);

    // latchCount wrap
    do_reset();
    repeat (255) do_latch();
    chk("latchCount_255", 32'(lcnt), 32'd255);
    do_latch();
    chk("latchCount_wrap", 32'(lcnt), 32'd0);

    // A/B across four reads (turbo alternates when built in)
    do_reset();
    btn = 8'h03;
    for (int r = 0; r < 4; r++) begin
      do_latch();
      read_bits(seq);
`ifdef NES_RESPONDER_TURBO_EN
      exp_ab = (r % 2 == 0) ? 2'b00 : 2'b11;
`else
      exp_ab = 2'b00;
`endif
      chk("turbo_read", 32'(seq), 32'({6'b111111, exp_ab}));
    end

    // Randomized transactions, checked by the per-cycle compare
    for (int t = 0; t < 150; t++) begin
      done_before = n_done;
      btn = 8'($urandom);
      if ($urandom_range(0, 3) == 0 && !pulse) begin
        latch = 1'b1;
        pulse = 1'b1;
      end else begin
        latch = 1'b1;
      end
      tick($urandom_range(1, 6));
      latch = 1'b0;
      if ($urandom_range(0, 3) == 0) pulse = 1'b1;
      else pulse = 1'b0;
      tick($urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) btn = 8'($urandom);
      for (int p = $urandom_range(0, 11); p > 0; p--) begin
        pulse = 1'b1;
        tick($urandom_range(1, 5));
        pulse = 1'b0;
        tick($urandom_range(1, 5));
        if ($urandom_range(0, 39) == 0) begin
          rst_n = 1'b0;
          tick($urandom_range(1, 2));
          rst_n = 1'b1;
        end
      end
      if ($urandom_range(0, 9) == 0) tick(TMO + 10);
      else tick($urandom_range(0, 6));
      if (done_before > n_done) chk("done_count_monotonic", 32'(n_done), 32'(done_before));
    end
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/nes_controller_responder.md
Name: nes_controller_responder

Overview:
- Controller-side (device) end of the NES serial controller link; the console-side reader drives latch/pulse and samples data.
- Captures an 8-bit button word on latch and shifts it out, active-low, one bit per pulse rising edge, emulating a 4021 shift register.
- Used as a bench/loopback partner for the controller reader, and as a controller emulator when one board drives another.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on CONTROLLER_LATCH and CONTROLLER_PULSE (legal 2..4).
- TAIL_LEVEL, 0, CONTROLLER_DATA level driven after all 8 bits have been shifted.
- TIMEOUT_CYCLES, 65535, pixelClock cycles without a pulse edge in SHIFTING before abort; 0 disables the timeout.

Ports:
- pixelClock  input  1  single design clock; all logic on rising edge.
- resetN  input  1  synchronous, active-low reset.
- CONTROLLER_LATCH  input  1  latch from the reader; high loads buttons.
- CONTROLLER_PULSE  input  1  shift clock from the reader; rising edge advances one bit.
- CONTROLLER_DATA  output  1  serial data, active-low (0 = pressed).
- buttons  input  8  live button state, 1 = pressed; bit0 = A, then B, Select, Start, Up, Down, Left, bit7 = Right.
- readDone  output  1  one-cycle strobe after the 8th bit is shifted.
- bitIndex  output  4  bits shifted since the last latch (0..8).
- latchCount  output  8  completed latch falling edges, mod 256.

Behaviour:
- **Reset** (resetN low at a pixelClock edge):
  - state = IDLE, CONTROLLER_DATA = 1, snapshot = 8'h00, bitIndex = 0, readDone = 0, latchCount = 0, timeout counter = 0.
  - Synchronizer flops reset to 0.
  - Reset mid-shift aborts immediately; no readDone is generated.
- **Input conditioning:**
  - LATCH and PULSE pass through SYNC_STAGES flops, then a one-flop edge detector.
  - CONTROLLER_DATA responds 3 cycles after an input edge (default SYNC_STAGES).
- **State machine:**
  - IDLE:
    - CONTROLLER_DATA = 1.
    - Synced latch high -> LOAD.
  - LOAD:
    - Each cycle: snapshot <= buttons, CONTROLLER_DATA <= ~buttons[0], bitIndex <= 0.
    - Pulse edges are ignored.
    - Latch falling edge: latchCount += 1 (wraps 255 -> 0), snapshot frozen, -> SHIFTING.
  - SHIFTING:
    - Pulse rising edge: snapshot >>= 1 (MSB fills 0), bitIndex += 1, CONTROLLER_DATA <= ~snapshot[1] (the next bit).
    - On the 8th edge: CONTROLLER_DATA <= TAIL_LEVEL, readDone pulses for one cycle, -> DONE.
    - Latch rising edge -> LOAD (a partial read is abandoned, no readDone).
    - Timeout: counter increments each cycle without a pulse edge and clears on any edge. Reaching TIMEOUT_CYCLES -> IDLE, CONTROLLER_DATA = 1, no readDone.
  - DONE:
    - CONTROLLER_DATA = TAIL_LEVEL.
    - Extra pulses are ignored; bitIndex saturates at 8.
    - Latch rising edge -> LOAD.
- **Simultaneous events:**
  - Synced latch rising and pulse rising in the same cycle: the latch wins and the pulse is discarded.
  - Latch falling and pulse rising in the same cycle: enter SHIFTING with bit 0 still presented; that pulse does not shift.
- **Button changes after latch falls** do not affect the current read.

Optional Feature:
- Macro: NES_RESPONDER_TURBO_EN.
- Defined:
  - A free-running turbo bit toggles on every latch falling edge.
  - During LOAD, snapshot[1:0] <= buttons[1:0] & {2{turbo}}, so A and B report pressed only on alternate reads. Other bits are unchanged.
  - turbo resets to 1.
- Undefined: no turbo logic is built; buttons load unmodified.

Test Plan:
- Reset then idle, no latch -> CONTROLLER_DATA = 1, bitIndex = 0, latchCount = 0, readDone never asserted.
- buttons = 8'h05 (A, Select), latch pulse, then 8 pulses -> bit sequence on DATA 0,1,0,1,1,1,1,1 sampled before each pulse, then TAIL_LEVEL 0. readDone high for exactly 1 cycle, latchCount = 1.
- Change buttons from 8'h05 to 8'hFF after latch falls, shift 8 -> sequence still matches 8'h05. A 9th and 10th pulse leave DATA = 0 and bitIndex = 8.
- Latch again after 3 pulses, with buttons = 8'h80 -> read restarts from bit 0. No readDone for the aborted read; the final bit (Right) reads 0.
- TIMEOUT_CYCLES = 100: latch, 2 pulses, then silence -> at cycle 100 DATA = 1, state IDLE, no readDone. Also check 256 latches -> latchCount wraps to 0.
- NES_RESPONDER_TURBO_EN defined, buttons = 8'h03 held, 4 full reads -> bits 0/1 read pressed, released, pressed, released. With the macro undefined -> pressed on all 4 reads.
